// File: rtl/count_macro_sequencer.sv
// count_macro_sequencer
//   Bring-up controller for the 3.3 V 4-bit count macro. It generates the
//   macro's clock and active-low reset and counts the pulses it issues. It reads
//   the macro's count back through a 2-flop synchroniser and compares it with
//   the expected value after reset and after every pulse. It reports pass/fail,
//   a saturating error count and the first failing pulse index.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   start          single-cycle run request (accepted in IDLE or DONE only)
//   abort          synchronous abort of a run in progress
//   pulse_count    number of macro clock pulses to issue
//   half_period    high/low time of each macro_clk phase in clk cycles (0 -> 1)
//   macro_count    count read back from the macro (asynchronous to clk)
//   macro_clk      clock to the macro, straight from a flop
//   macro_n_reset  active-low reset to the macro
//   busy, done     run in progress / one-cycle completion pulse
//   pass           last completed run had no mismatches
//   err_count      mismatches in current/last run, saturating at 255
//   fail_valid     at least one mismatch seen in this run
//   fail_idx       pulse index of first mismatch (0 = post-reset check)
//   last_count     most recent synchronised sample taken at a compare
module count_macro_sequencer #(
    parameter int NPULSE_W      = 8,
    parameter int DIV_W         = 8,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [NPULSE_W-1:0] pulse_count,
    input  logic [DIV_W-1:0]    half_period,
    input  logic [3:0]          macro_count,
    output logic                macro_clk,
    output logic                macro_n_reset,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [7:0]          err_count,
    output logic                fail_valid,
    output logic [NPULSE_W-1:0] fail_idx,
    output logic [3:0]          last_count
);

    // Phase timer must hold the longest of hp, RST_CYCLES and SETTLE_CYCLES.
    localparam int TMR_W = (DIV_W > 16) ? DIV_W : 16;

    typedef enum logic [2:0] {
        IDLE, RST, RSETTLE, HI, LO, SETTLE, FINISH, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [NPULSE_W-1:0] npulse_q, npulse_d;
    logic [DIV_W-1:0]    hp_q, hp_d;
    logic [NPULSE_W-1:0] issued_q, issued_d;
    logic [3:0]          exp_q, exp_d;
    logic [3:0]          sync1_q, sync1_d;
    logic [3:0]          sync2_q, sync2_d;
    logic                macro_clk_q, macro_clk_d;
    logic                macro_n_reset_q, macro_n_reset_d;
    logic                pass_q, pass_d;
    logic [7:0]          err_count_q, err_count_d;
    logic                fail_valid_q, fail_valid_d;
    logic [NPULSE_W-1:0] fail_idx_q, fail_idx_d;
    logic [3:0]          last_count_q, last_count_d;

    logic                busy_w;
    logic                do_cmp;
    logic                enter_hi;
    logic [NPULSE_W-1:0] cmp_idx;

    assign busy_w = (state_q == RST) || (state_q == RSETTLE) || (state_q == HI) ||
                    (state_q == LO)  || (state_q == SETTLE);

    always_comb begin
        state_d         = state_q;
        timer_d         = (timer_q != '0) ? timer_q - TMR_W'(1) : timer_q;
        npulse_d        = npulse_q;
        hp_d            = hp_q;
        issued_d        = issued_q;
        exp_d           = exp_q;
        sync1_d         = macro_count;
        sync2_d         = sync1_q;
        pass_d          = pass_q;
        err_count_d     = err_count_q;
        fail_valid_d    = fail_valid_q;
        fail_idx_d      = fail_idx_q;
        last_count_d    = last_count_q;
        do_cmp          = 1'b0;
        enter_hi        = 1'b0;
        cmp_idx         = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RST;
                    timer_d      = TMR_W'(RST_CYCLES - 1);
                    npulse_d     = pulse_count;
                    hp_d         = (half_period == '0) ? DIV_W'(1) : half_period;
                    issued_d     = '0;
                    exp_d        = '0;
                    pass_d       = 1'b0;
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    fail_idx_d   = '0;
                end
            end
            RST: begin
                if (timer_q == '0) begin
                    state_d = RSETTLE;
                    timer_d = TMR_W'(SETTLE_CYCLES - 1);
                end
            end
            RSETTLE: begin
                if (timer_q == '0) begin
                    do_cmp  = 1'b1;
                    cmp_idx = '0;
                    if (npulse_q == '0) state_d = FINISH;
                    else                enter_hi = 1'b1;
                end
            end
            HI: begin
                if (timer_q == '0) begin
                    state_d = LO;
                    timer_d = TMR_W'(hp_q) - TMR_W'(1);
                end
            end
            LO: begin
                if (timer_q == '0) begin
                    state_d = SETTLE;
                    timer_d = TMR_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    do_cmp  = 1'b1;
                    cmp_idx = issued_q;
                    if (issued_q == npulse_q) state_d = FINISH;
                    else                      enter_hi = 1'b1;
                end
            end
            FINISH: state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Expected value and pulse index advance together on each HI entry;
        // the compare that triggered this entry still sees the old exp_q.
        if (enter_hi) begin
            state_d  = HI;
            timer_d  = TMR_W'(hp_q) - TMR_W'(1);
            exp_d    = exp_q + 4'd1;
            issued_d = issued_q + NPULSE_W'(1);
        end

        // Abort wins over everything in a busy state, including a compare
        // landing in the same cycle, so the result fields stay as they were.
        if (abort && busy_w) begin
            state_d = IDLE;
            do_cmp  = 1'b0;
        end

        if (do_cmp) begin
            last_count_d = sync2_q;
            if (sync2_q != exp_q) begin
                if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                if (!fail_valid_q) begin
                    fail_valid_d = 1'b1;
                    fail_idx_d   = cmp_idx;
                end
            end
        end

        // Resolve pass on the way into FINISH so it is valid alongside done,
        // including a mismatch found by the final compare.
        if (state_d == FINISH)    pass_d = (err_count_d == 8'd0);
        else if (state_d == IDLE) pass_d = 1'b0;

        macro_clk_d     = (state_d == HI);
        macro_n_reset_d = !((state_d == IDLE) || (state_d == RST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            npulse_q        <= '0;
            hp_q            <= '0;
            issued_q        <= '0;
            exp_q           <= '0;
            sync1_q         <= '0;
            sync2_q         <= '0;
            macro_clk_q     <= 1'b0;
            macro_n_reset_q <= 1'b0;
            pass_q          <= 1'b0;
            err_count_q     <= '0;
            fail_valid_q    <= 1'b0;
            fail_idx_q      <= '0;
            last_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            npulse_q        <= npulse_d;
            hp_q            <= hp_d;
            issued_q        <= issued_d;
            exp_q           <= exp_d;
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            macro_clk_q     <= macro_clk_d;
            macro_n_reset_q <= macro_n_reset_d;
            pass_q          <= pass_d;
            err_count_q     <= err_count_d;
            fail_valid_q    <= fail_valid_d;
            fail_idx_q      <= fail_idx_d;
            last_count_q    <= last_count_d;
        end
    end

    assign macro_clk     = macro_clk_q;
    assign macro_n_reset = macro_n_reset_q;
    assign busy          = busy_w;
    assign done          = (state_q == FINISH);
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign fail_valid    = fail_valid_q;
    assign fail_idx      = fail_idx_q;
    assign last_count    = last_count_q;

endmodule

// File: tb/tb_count_macro_sequencer.sv
// Self-checking bench for count_macro_sequencer: a behavioural macro model
// (async reset, 4-bit counter on macro_clk rise, optional stuck-at-0 bits)
// and a per-run reference computed directly from the pulse arithmetic.
module tb_count_macro_sequencer;

    localparam int RSTC = 4;
    localparam int SETC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pulse_count = '0;
    logic [7:0] half_period = '0;
    logic [3:0] macro_count;
    logic       macro_clk, macro_n_reset, busy, done, pass, fail_valid;
    logic [7:0] err_count, fail_idx;
    logic [3:0] last_count;

    int n_chk = 0;
    int n_fail = 0;

    count_macro_sequencer #(
        .NPULSE_W(8), .DIV_W(8), .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pulse_count(pulse_count), .half_period(half_period),
        .macro_count(macro_count), .macro_clk(macro_clk),
        .macro_n_reset(macro_n_reset), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .fail_idx(fail_idx),
        .last_count(last_count)
    );

    always #5 clk = ~clk;

    // Macro model
    logic [3:0] mcnt;
    logic [3:0] stuck_mask = 4'd0;
    always @(posedge macro_clk or negedge macro_n_reset)
        if (!macro_n_reset) mcnt <= 4'd0;
        else                mcnt <= mcnt + 4'd1;
    assign macro_count = mcnt & ~stuck_mask;

    // macro_clk monitor: rising edges and high-phase lengths in clk cycles
    int   rise_cnt = 0;
    int   bad_cnt = 0;
    int   hi_len = 0;
    int   mon_hp = 1;
    logic mclk_prev = 1'b0;
    always @(negedge clk) begin
        if (macro_clk) begin
            if (!mclk_prev) rise_cnt++;
            hi_len++;
        end else if (hi_len != 0) begin
            if (hi_len != mon_hp) bad_cnt++;
            hi_len = 0;
        end
        mclk_prev = macro_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run. inject_at >= 0 pulses a conflicting start mid-run.
    task automatic run(input int n, input int hp, input logic [3:0] mask, input int inject_at);
        int hpe, lat, cyc, r0, b0, errs, fidx, lastc;
        bit fv;
        hpe = (hp == 0) ? 1 : hp;
        lat = RSTC + SETC + n * (2 * hpe + SETC);
        errs = 0; fv = 0; fidx = 0;
        for (int i = 0; i <= n; i++) begin
            int e, o;
            e = i % 16;
            o = e & ~int'(mask);
            if (o != e) begin
                errs++;
                if (!fv) begin fv = 1; fidx = i; end
            end
        end
        if (errs > 255) errs = 255;
        lastc = (n % 16) & ~int'(mask);

        stuck_mask  = mask;
        mon_hp      = hpe;
        r0          = rise_cnt;
        b0          = bad_cnt;
        pulse_count = 8'(n);
        half_period = 8'(hp);
        start       = 1'b1;
        tick();
        start       = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 20000) begin
            if (cyc == inject_at) begin
                start       = 1'b1;
                pulse_count = 8'(n + 5);
                half_period = 8'(hp + 2);
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("latency",    32'(cyc),        32'(lat));
        chk("done",       32'(done),       32'd1);
        chk("busy_done",  32'(busy),       32'd0);
        chk("pass",       32'(pass),       32'(errs == 0));
        chk("err_count",  32'(err_count),  32'(errs));
        chk("fail_valid", 32'(fail_valid), 32'(fv));
        chk("fail_idx",   32'(fail_idx),   32'(fidx));
        chk("last_count", 32'(last_count), 32'(lastc));
        chk("rises",      32'(rise_cnt - r0), 32'(n));
        chk("hi_phase",   32'(bad_cnt - b0),  32'd0);
        tick();
        chk("done_pulse", 32'(done),          32'd0);
        chk("hold_pass",  32'(pass),          32'(errs == 0));
        chk("done_nrst",  32'(macro_n_reset), 32'd1);
        chk("done_mclk",  32'(macro_clk),     32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mclk"},  32'(macro_clk),     32'd0);
        chk({tag, "_nrst"},  32'(macro_n_reset), 32'd0);
        chk({tag, "_busy"},  32'(busy),          32'd0);
        chk({tag, "_done"},  32'(done),          32'd0);
        chk({tag, "_pass"},  32'(pass),          32'd0);
        chk({tag, "_err"},   32'(err_count),     32'd0);
        chk({tag, "_fv"},    32'(fail_valid),    32'd0);
        chk({tag, "_fidx"},  32'(fail_idx),      32'd0);
        chk({tag, "_last"},  32'(last_count),    32'd0);
    endtask

    initial begin
        int r0, w, dones;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Directed runs
        run(20, 1, 4'd0, -1);   // wrap through 15 -> 0
        run(0,  1, 4'd0, -1);   // post-reset check only
        run(8,  1, 4'd4, -1);   // bit 2 stuck at 0
        run(4,  5, 4'd0, -1);   // divider
        run(4,  0, 4'd0, -1);   // zero divider behaves as 1
        run(12, 2, 4'd0, 10);   // start while busy is ignored

        // Abort during the 3rd HI phase, with bit 0 stuck so errors exist
        stuck_mask  = 4'd1;
        mon_hp      = 3;
        r0          = rise_cnt;
        pulse_count = 8'd10;
        half_period = 8'd3;
        start       = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while ((rise_cnt - r0) < 3 && w < 500) begin
            tick();
            w++;
        end
        chk("abort_reach", 32'(w < 500), 32'd1);
        chk("abort_in_hi", 32'(macro_clk), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy),          32'd0);
        chk("abort_nrst", 32'(macro_n_reset), 32'd0);
        chk("abort_mclk", 32'(macro_clk),     32'd0);
        chk("abort_pass", 32'(pass),          32'd0);
        chk("abort_err",  32'(err_count),     32'd1);
        chk("abort_fv",   32'(fail_valid),    32'd1);
        chk("abort_fidx", 32'(fail_idx),      32'd1);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            // abort outside busy must be ignored (and not disturb IDLE)
            abort = (i == 5);
            tick();
        end
        abort = 1'b0;
        chk("abort_nodone", 32'(dones), 32'd0);
        run(3, 1, 4'd0, -1);

        // Asynchronous reset mid-run
        stuck_mask  = 4'd2;
        mon_hp      = 2;
        r0          = rise_cnt;
        pulse_count = 8'd10;
        half_period = 8'd2;
        start       = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while ((rise_cnt - r0) < 4 && w < 500) begin
            tick();
            w++;
        end
        chk("mrst_reach", 32'(macro_clk), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomised runs
        for (int k = 0; k < 8; k++) begin
            int n, hp;
            logic [3:0] m;
            n  = int'($urandom_range(0, 40));
            hp = int'($urandom_range(0, 4));
            m  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            run(n, hp, m, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/count_macro_sequencer.md
Name: count_macro_sequencer

Overview:
- Digital controller that exercises the 3.3 V 4-bit count macro through level-shifted pins.
- Generates the macro's clock and active-low reset, counts the pulses it issues, and reads back the macro's 4-bit count.
- Compares the readback with the expected value after reset and after every pulse, and reports pass/fail, a saturating error count and the first failing pulse.
- Sits in the 1.8 V digital domain of the tile and is driven by ui_in/uo_out for bring-up testing.

Parameters:
- NPULSE_W, 8, width of the pulse-count request and the pulse index.
- DIV_W, 8, width of the half-period setting, in clk cycles.
- RST_CYCLES, 4, number of clk cycles macro_n_reset is held low at the start of a run.
- SETTLE_CYCLES, 3, clk cycles waited before each compare; must be ≥ 3 (2-flop sync plus margin).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a run.
- abort  input  1  synchronous abort of a run in progress.
- pulse_count  input  NPULSE_W  number of macro clock pulses to issue.
- half_period  input  DIV_W  high and low time of each macro_clk phase, in clk cycles; 0 is treated as 1.
- macro_count  input  4  count read back from the macro; asynchronous to clk.
- macro_clk  output  1  clock to the macro.
- macro_n_reset  output  1  active-low reset to the macro.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 when the last completed run had no mismatches.
- err_count  output  8  mismatches in the current or last run; saturates at 255.
- fail_valid  output  1  at least one mismatch has been seen in this run.
- fail_idx  output  NPULSE_W  pulse index of the first mismatch; 0 means the post-reset check.
- last_count  output  4  most recent synchronised macro_count sample.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - macro_clk = 0, macro_n_reset = 0, busy = 0, done = 0, pass = 0.
  - err_count = 0, fail_valid = 0, fail_idx = 0, last_count = 0.
  - Both synchroniser stages = 0.
- Synchroniser: macro_count passes through a 2-flop synchroniser. Compares use the output of the second stage only.
- Start:
  - Accepted only in IDLE or DONE; ignored while busy.
  - On acceptance, pulse_count and half_period are latched and err_count, fail_valid, fail_idx and pass are cleared.
  - busy rises in the next cycle.
- States:
  - IDLE:
    - macro_clk = 0, macro_n_reset = 0.
    - On accepted start, go to RST.
  - RST:
    - macro_n_reset = 0 for RST_CYCLES cycles, then go to RSETTLE.
  - RSETTLE:
    - macro_n_reset = 1; wait SETTLE_CYCLES.
    - On the last cycle compare against expected value 0 (index 0).
    - If pulse_count = 0, go to FINISH; otherwise go to HI.
  - HI:
    - macro_clk = 1 for hp cycles, where hp = max(half_period, 1).
    - The expected value increments by 1 mod 16 on entry (wraps 15 to 0).
  - LO:
    - macro_clk = 0 for hp cycles, then go to SETTLE.
  - SETTLE:
    - macro_clk = 0 for SETTLE_CYCLES; on the last cycle compare against the expected value (index = pulses issued).
    - If issued = pulse_count, go to FINISH; otherwise go to HI.
  - FINISH:
    - done = 1 for one cycle; pass = (err_count == 0); busy = 0 in the same cycle; go to DONE.
  - DONE:
    - macro_n_reset stays 1 so the final count remains observable; macro_clk = 0.
    - Results are held until the next accepted start.
- Compare step:
  - Each compare writes last_count.
  - On mismatch, err_count increments, saturating at 255.
  - On the first mismatch only, fail_valid is set and fail_idx captures the index.
- Latency: done asserts exactly RST_CYCLES + SETTLE_CYCLES + N·(2·hp + SETTLE_CYCLES) cycles after busy rises (N = latched pulse_count).
- Abort:
  - Effective in any busy state: go to IDLE in the next cycle; macro_clk = 0, macro_n_reset = 0, busy = 0.
  - No done pulse; pass = 0; err_count and fail fields hold their values.
  - Abort takes priority over start in the same cycle.
  - Abort outside busy is ignored.
- rst_n low mid-run: immediate return to reset values; macro_clk drops asynchronously.
- macro_clk is driven directly from a flop; it is never gated or combinational.

Test Plan:
- Bench uses a macro model with async reset and a 4-bit counter incrementing on the macro_clk rising edge.
- Healthy run: pulse_count = 20, half_period = 1 with defaults -> done 107 cycles after busy rises, pass = 1, err_count = 0, last_count = 4 (20 mod 16, wrap exercised).
- Zero pulses: pulse_count = 0 -> only the post-reset check runs; done after 7 cycles, pass = 1, macro_clk never rises.
- Stuck-at fault: model bit 2 stuck at 0, pulse_count = 8 -> pass = 0, fail_idx = 4, err_count = 4 (mismatches at counts 4, 5, 6, 7).
- Divider and zero-divider: half_period = 5 gives 5-cycle macro_clk phases; half_period = 0 gives timing identical to half_period = 1.
- Abort and restart:
  - Abort during the 3rd HI phase -> busy low next cycle, no done, macro_n_reset = 0.
  - A subsequent start with pulse_count = 3 -> pass = 1, err_count cleared.
- Robustness:
  - start asserted while busy is ignored, so the original run's timing is unchanged.
  - rst_n asserted mid-run -> all outputs return to reset values asynchronously.
